// File: rtl/fp_pkg.sv
// Shared definitions for the sequential FP divider: FSM states,
// IEEE-754 binary32 constants and the bit positions inside fflags.
package fp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } div_state_t;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
  localparam int          FP_BIAS      = 127;

  // Positions inside the {NV, DZ, OF, UF, NX} flag vector
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

endpackage

// File: rtl/fp_div_round.sv
// Combinational normalise / round-to-nearest-even / pack stage of the
// divider. Takes the raw 26-bit quotient, a remainder-nonzero sticky
// indication, the biased exponent and the sign. Flag outputs exist only
// when FP_DIV_FLAGS_EN is defined; otherwise fflags is constant zero.
module fp_div_round
  import fp_pkg::*;
(
  input  logic              [25:0] q,
  input  logic                     rem_nz,
  input  logic signed       [9:0]  exp_in,
  input  logic                     sign,
  output logic              [31:0] result,
  output logic              [4:0]  fflags
);

  logic [22:0]        frac;
  logic [23:0]        sum;
  logic               g;
  logic               s;
  logic               inc;
  logic signed [9:0]  e;

  // Normalise on the quotient MSB, round, then saturate to inf or flush to zero
  always_comb begin
    frac   = '0;
    g      = 1'b0;
    s      = 1'b0;
    e      = exp_in;
    inc    = 1'b0;
    sum    = '0;
    result = '0;
    fflags = '0;
    if (q[25]) begin
      frac = q[24:2];
      g    = q[1];
      s    = q[0] | rem_nz;
    end else begin
      frac = q[23:1];
      g    = q[0];
      s    = rem_nz;
      e    = exp_in - 10'sd1;
    end
    inc = g & (s | frac[0]);
    sum = {1'b0, frac} + {23'd0, inc};
    if (sum[23]) begin
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) begin
      result = {sign, 8'hFF, 23'd0};
`ifdef FP_DIV_FLAGS_EN
      fflags[FLAG_OF] = 1'b1;
      fflags[FLAG_NX] = 1'b1;
`endif
    end else if (e <= 10'sd0) begin
      result = {sign, 31'd0};
`ifdef FP_DIV_FLAGS_EN
      fflags[FLAG_UF] = 1'b1;
      fflags[FLAG_NX] = 1'b1;
`endif
    end else begin
      result = {sign, e[7:0], sum[22:0]};
`ifdef FP_DIV_FLAGS_EN
      fflags[FLAG_NX] = g | s;
`endif
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider (fdiv.s) with start/busy/done handshake.
// Restoring division produces one quotient bit per cycle; special
// operands finish in a single cycle. Optional macro FP_DIV_FLAGS_EN
// enables exception flag generation; without it fflags reads zero.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int ITERS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  div_state_t         state;
  logic [4:0]         cnt;
  logic [25:0]        q;
  logic [24:0]        rem;
  logic [23:0]        mb;
  logic signed [9:0]  exp_q;
  logic               sign_q;

  logic               a_zero, a_inf, a_nan;
  logic               b_zero, b_inf, b_nan;
  logic               special;
  logic [31:0]        sp_res;
  logic [4:0]         sp_flags;
  logic signed [9:0]  exp_calc;
  logic               ge;
  logic [24:0]        rem_sel;
  logic [24:0]        rem_next;
  logic [31:0]        rnd_res;
  logic [4:0]         rnd_flags;

  // Subnormals count as zero: any zero exponent field is classified as zero
  assign a_zero = (a[30:23] == 8'h00);
  assign b_zero = (b[30:23] == 8'h00);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

  assign exp_calc = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'(FP_BIAS);

  // Resolve special operand combinations in priority order
  always_comb begin
    special  = 1'b1;
    sp_res   = '0;
    sp_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res = FP_CANON_NAN;
`ifdef FP_DIV_FLAGS_EN
      sp_flags[FLAG_NV] = (a_nan && !a[22]) || (b_nan && !b[22]) ||
                          (a_zero && b_zero) || (a_inf && b_inf);
`endif
    end else if (b_zero && !a_inf) begin
      sp_res = {a[31] ^ b[31], 8'hFF, 23'd0};
`ifdef FP_DIV_FLAGS_EN
      sp_flags[FLAG_DZ] = 1'b1;
`endif
    end else if (a_inf) begin
      sp_res = {a[31] ^ b[31], 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      sp_res = {a[31] ^ b[31], 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring-division step: subtract when possible, then shift left
  always_comb begin
    ge       = (rem >= {1'b0, mb});
    rem_sel  = ge ? (rem - {1'b0, mb}) : rem;
    rem_next = rem_sel << 1;
  end

  fp_div_round u_round (
    .q      (q),
    .rem_nz (rem != 25'd0),
    .exp_in (exp_q),
    .sign   (sign_q),
    .result (rnd_res),
    .fflags (rnd_flags)
  );

  // Control FSM with registered handshake outputs; flush aborts from any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      q      <= '0;
      rem    <= '0;
      mb     <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      fflags <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            sign_q <= a[31] ^ b[31];
            if (special) begin
              result <= sp_res;
              fflags <= sp_flags;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              rem   <= {2'b01, a[22:0]};
              mb    <= {1'b1, b[22:0]};
              exp_q <= exp_calc;
              q     <= '0;
              cnt   <= '0;
              state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          q   <= {q[24:0], ge};
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER) begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          result <= rnd_res;
          fflags <= rnd_flags;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Sequential single-precision floating-point divider that fills the empty `fdiv.s` slot (ALU control code 3) in the FP execute stage. It sits beside the combinational FP ALU and takes the same decoded operands. Its result feeds the execute-stage result mux, which steers it to FP writeback. Because a divide takes many cycles, the block uses a start/busy/done handshake so the pipeline control can stall until the result is ready.

## Interface
Parameters:
- `ITERS`, default 26: number of quotient bits produced, one per cycle. Only 26 is supported.

Ports:
- `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `start`, input, 1 bit: begin a divide. Sampled only in IDLE.
- `flush`, input, 1 bit: synchronous abort of an in-flight divide.
- `a`, input, 32 bits: dividend, IEEE-754 binary32. Sampled when `start` is accepted.
- `b`, input, 32 bits: divisor, IEEE-754 binary32. Sampled when `start` is accepted.
- `busy`, output, 1 bit: high in every state except IDLE.
- `done`, output, 1 bit: one-cycle pulse marking that `result` is valid.
- `result`, output, 32 bits: quotient. Holds its value until the next accepted `start`.
- `fflags`, output, 5 bits: exception flags {NV, DZ, OF, UF, NX}. Valid while `done` is high.

## Operation
- States:
  - IDLE.
  - ITER: count 0..25.
  - ROUND.
  - DONE.
- IDLE + `start`:
  - Latch the result sign as `a[31]^b[31]`.
  - Classify both operands.
  - If a special case applies, go to DONE with the special result.
  - Otherwise go to ITER.
- Subnormal inputs are flushed to a zero of the same sign before classification.
- Special cases, in priority order:
  - Either operand is NaN, or 0/0, or inf/inf: result 0x7FC00000 (canonical NaN). NV is set only for sNaN, 0/0 and inf/inf.
  - finite/0: ±inf, DZ.
  - inf/finite: ±inf.
  - 0/nonzero or finite/inf: ±0.
- Normal path:
  - Exponent: `E = ea - eb + 127`, held as a 10-bit signed value.
  - Mantissas: `ma = {1,a[22:0]}`, `mb = {1,b[22:0]}`.
  - ITER runs restoring division, one quotient bit per cycle, MSB first, giving Q[25:0] and a remainder R.
- Normalise:
  - If Q[25]=1: `m = Q[25:2]`, `G = Q[1]`, `S = Q[0] | (R≠0)`.
  - Else: `m = Q[24:1]`, `G = Q[0]`, `S = (R≠0)`, and `E = E - 1`.
- ROUND (round to nearest, ties to even):
  - Increment `m` when `G & (S | m[0])`.
  - If `m` carries out, set `m = 1.0` and `E = E + 1`.
  - NX = `G | S`.
  - If `E ≥ 255`: result ±inf, with OF and NX.
  - If `E ≤ 0`: result ±0 (flush to zero), with UF and NX.
- DONE: assert `done` for one cycle, then go to IDLE.
- `flush` is high in any state: next state is IDLE. No `done` is produced, and `result` is unchanged.
- `flush` takes priority over `start`.
- `start` while `busy` is high is ignored.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `result` = 0, `fflags` = 0.
- A reset arriving mid-divide drops the operation immediately and asynchronously.
- `start` is accepted in cycle T:
  - `busy` is high from cycle T+1.
  - Special case: `done` is high in cycle T+1.
  - Normal case: ITER occupies cycles T+1..T+26, ROUND is T+27, and `done` is high in T+28.
- `busy` falls in the cycle after the `done` pulse.
- A new `start` is accepted in that same cycle, giving a back-to-back throughput of 1 divide per 29 cycles.

## Configuration
- Macro `FP_DIV_FLAGS_EN`:
  - Defined: `fflags` is computed as described above.
  - Undefined: `fflags` is tied to 0 and all flag logic is removed. The result values are identical either way.

## Structure
- Shared package `fp_pkg` holds:
  - The state enum.
  - Constants `FP_CANON_NAN = 32'h7FC00000`, `FP_BIAS = 127`.
  - Flag bit indices.
- One sub-module, `fp_div_round`: combinational normalise/round/pack, taking Q, R, E and the sign, and producing `result` and `fflags`.

## Test plan
- Exact quotient: 0x40C00000 / 0x40000000 → 0x40400000 with `done` at T+28 and `fflags` = 0.
- Inexact quotient: 0x3F800000 / 0x40400000 → 0x3EAAAAAB with NX only.
- Divide by zero: 0x3F800000 / 0x00000000 → 0x7F800000 with DZ and `done` at T+1.
- Invalid: 0/0 → 0x7FC00000 with NV. Also 0x7F800000 / 0xFF800000 → 0x7FC00000 with NV.
- Overflow: 0x7F7FFFFF / 0x3E800000 → 0x7F800000 with OF and NX.
- Abort and reset:
  - Assert `flush` at T+10 → no `done`, `busy` low at T+11.
  - Deassert `rst_n` at T+5 → all outputs 0 immediately.
  - A subsequent divide completes correctly.
